// File: rtl/clkgen_pkg.sv
// Shared types and helpers for the multi-channel clock-enable generator.
// Holds the per-channel config record, reset defaults and divider/phase helpers.
package clkgen_pkg;

  localparam int DIVW = 8;
  localparam logic [DIVW-1:0] DEF_DIV = 8'd1;
  localparam logic [31:0]     DEF_EN  = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [DIVW-1:0] div;
    logic [DIVW-1:0] phase;
    logic            en;
  } chan_cfg_t;

  localparam logic [DIVW-1:0] DIV_ONE = 8'd1;

  // A programmed divider of 0 behaves as 1.
  function automatic logic [DIVW-1:0] eff_div(input logic [DIVW-1:0] div);
    return (div == '0) ? DIV_ONE : div;
  endfunction

  function automatic logic [DIVW-1:0] clamp_phase(input logic [DIVW-1:0] div,
                                                  input logic [DIVW-1:0] phase);
    logic [DIVW-1:0] d;
    d = eff_div(div);
    return (phase >= d) ? (d - DIV_ONE) : phase;
  endfunction

endpackage

// File: rtl/clkgen_chan.sv
// One channel slice: wrapping divide counter, registered strobe/square-wave outputs
// and single-cycle phase step (hold for delay, skip one count for advance).
module clkgen_chan #(
  parameter int DIVW = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic [DIVW-1:0] div_i,
  input  logic [DIVW-1:0] phase_i,
  input  logic            en_i,
  input  logic            locked_i,
  input  logic            step_i,
  input  logic            delay_i,
  output logic            clken_o,
  output logic            clkdiv_o
);

  localparam logic [DIVW-1:0] ONE  = 1;
  localparam logic [DIVW:0]   ONEW = 1;
  localparam logic [DIVW:0]   TWOW = 2;

  logic [DIVW-1:0] cnt_q, cnt_d;
  logic [DIVW:0]   adv, half, divw;
  logic            clken_q, clken_d, clkdiv_q, clkdiv_d;

  always_comb begin
    divw     = {1'b0, div_i};
    adv      = {1'b0, cnt_q} + TWOW;
    half     = (divw + ONEW) >> 1;
    cnt_d    = (cnt_q == div_i - ONE) ? '0 : cnt_q + ONE;
    clken_d  = en_i & locked_i & (cnt_q == phase_i);
    clkdiv_d = en_i & locked_i & ({1'b0, cnt_q} < half);
    if (step_i) begin
      if (delay_i) begin
        cnt_d = cnt_q;
      end else if (div_i == ONE) begin
        cnt_d = '0;
      end else if (adv >= divw) begin
        // With d >= 2, cnt+2 < 2d, so one subtraction completes the modulo.
        cnt_d = DIVW'(adv - divw);
      end else begin
        cnt_d = adv[DIVW-1:0];
      end
    end
    if (clr_i) begin
      cnt_d    = '0;
      clken_d  = 1'b0;
      clkdiv_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      clken_q  <= 1'b0;
      clkdiv_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      clken_q  <= clken_d;
      clkdiv_q <= clkdiv_d;
    end
  end

  assign clken_o  = clken_q;
  assign clkdiv_o = clkdiv_q;

endmodule

// File: rtl/clkgen_nch.sv
// Programmable NCH-channel clock-enable generator: shadow/active config, commit,
// lock sequencing, standby and phase-step decode around NCH channel slices.
module clkgen_nch #(
  parameter int              NCH         = 5,
  parameter int              DIVW        = clkgen_pkg::DIVW,
  parameter int              SELW        = 3,
  parameter logic [DIVW-1:0] DEF_DIV     = clkgen_pkg::DEF_DIV,
  parameter logic [NCH-1:0]  DEF_EN      = clkgen_pkg::DEF_EN[NCH-1:0],
  parameter int              LOCK_CYCLES = 64
) (
  input  logic            refclk,
  input  logic            pllreset,
  input  logic            stdby,
  input  logic            cfg_we,
  input  logic [SELW-1:0] cfg_sel,
  input  logic [DIVW-1:0] cfg_div,
  input  logic [DIVW-1:0] cfg_phase,
  input  logic            cfg_en,
  input  logic            cfg_update,
  input  logic            phasestep,
  input  logic            phaseupdown,
  input  logic [SELW-1:0] phcntsel,
  output logic [NCH-1:0]  clken,
  output logic [NCH-1:0]  clkdiv,
  output logic            phasedone,
  output logic            locked
);

  import clkgen_pkg::*;

  localparam int            LCW     = $clog2(LOCK_CYCLES) + 1;
  localparam logic [LCW-1:0] LCK_END = LCW'(LOCK_CYCLES - 1);
  localparam logic [LCW-1:0] LCK_ONE = 1;
  localparam logic [SELW:0]  NCH_SEL = (SELW+1)'(NCH);

  chan_cfg_t      shadow_q [NCH];
  chan_cfg_t      shadow_d [NCH];
  chan_cfg_t      active_q [NCH];
  chan_cfg_t      active_d [NCH];
  logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
  logic           locked_q, locked_d;
  logic           phasedone_q;
  logic           sync_clr;
  logic           step_acc;

  always_comb begin
    sync_clr = cfg_update | stdby;
    step_acc = phasestep & locked_q & ~stdby & ~cfg_update & ({1'b0, phcntsel} < NCH_SEL);
    for (int i = 0; i < NCH; i++) begin
      shadow_d[i] = shadow_q[i];
      if (cfg_we && (cfg_sel == SELW'(i))) begin
        shadow_d[i].div   = cfg_div;
        shadow_d[i].phase = cfg_phase;
        shadow_d[i].en    = cfg_en;
      end
      // Commit takes the post-write shadow, so a same-cycle write is included.
      active_d[i] = active_q[i];
      if (cfg_update) begin
        active_d[i]       = shadow_d[i];
        active_d[i].phase = clamp_phase(shadow_d[i].div, shadow_d[i].phase);
      end
    end
    lock_cnt_d = lock_cnt_q;
    locked_d   = locked_q;
    if (sync_clr) begin
      lock_cnt_d = '0;
      locked_d   = 1'b0;
    end else if (!locked_q) begin
      if (lock_cnt_q == LCK_END) locked_d = 1'b1;
      else                       lock_cnt_d = lock_cnt_q + LCK_ONE;
    end
  end

  always_ff @(posedge refclk) begin
    if (pllreset) begin
      for (int i = 0; i < NCH; i++) begin
        shadow_q[i].div   <= DEF_DIV;
        shadow_q[i].phase <= '0;
        shadow_q[i].en    <= DEF_EN[i];
        active_q[i].div   <= DEF_DIV;
        active_q[i].phase <= '0;
        active_q[i].en    <= DEF_EN[i];
      end
      lock_cnt_q  <= '0;
      locked_q    <= 1'b0;
      phasedone_q <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
      lock_cnt_q  <= lock_cnt_d;
      locked_q    <= locked_d;
      phasedone_q <= step_acc;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    clkgen_chan #(.DIVW(DIVW)) u_chan (
      .clk_i    (refclk),
      .rst_i    (pllreset),
      .clr_i    (sync_clr),
      .div_i    (eff_div(active_q[g].div)),
      .phase_i  (active_q[g].phase),
      .en_i     (active_q[g].en),
      .locked_i (locked_q),
      .step_i   (step_acc && (phcntsel == SELW'(g))),
      .delay_i  (phaseupdown),
      .clken_o  (clken[g]),
      .clkdiv_o (clkdiv[g])
    );
  end

  assign phasedone = phasedone_q;
  assign locked    = locked_q;

endmodule

// File: tb/tb_clkgen_nch.sv
// Bench for clkgen_nch: a cycle model pushes the expected output word per cycle,
// popped after each edge; directed checks cover lock latency and step periods.
module tb_clkgen_nch;

  logic       refclk = 1'b0;
  logic       rst = 1'b1, stdby = 1'b0, we = 1'b0, en = 1'b0, upd = 1'b0;
  logic       pstep = 1'b0, pud = 1'b0;
  logic [2:0] sel = '0, psel = '0;
  logic [7:0] div = '0, ph = '0;
  logic [4:0] clken, clkdiv;
  logic       phasedone, locked;

  int n_chk = 0, n_err = 0, n = 0;
  logic [11:0] sb[$];
  int m_sdiv[5], m_sph[5], m_sen[5], m_adiv[5], m_aph[5], m_aen[5];
  int m_cnt[5], m_ce[5], m_cd[5];
  int m_lkc, m_lk, m_pd;

  clkgen_nch dut (
    .refclk(refclk), .pllreset(rst), .stdby(stdby),
    .cfg_we(we), .cfg_sel(sel), .cfg_div(div), .cfg_phase(ph), .cfg_en(en),
    .cfg_update(upd), .phasestep(pstep), .phaseupdown(pud), .phcntsel(psel),
    .clken(clken), .clkdiv(clkdiv), .phasedone(phasedone), .locked(locked)
  );

  always #5 refclk = ~refclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int d, acc;
    logic [11:0] e;
    if (rst) begin
      for (int i = 0; i < 5; i++) begin
        m_sdiv[i] = 1; m_sph[i] = 0; m_sen[i] = 1;
        m_adiv[i] = 1; m_aph[i] = 0; m_aen[i] = 1;
        m_cnt[i] = 0; m_ce[i] = 0; m_cd[i] = 0;
      end
      m_lkc = 0; m_lk = 0; m_pd = 0;
    end else begin
      if (we && sel < 5) begin
        m_sdiv[sel] = div; m_sph[sel] = ph; m_sen[sel] = en;
      end
      acc = (pstep && m_lk == 1 && !stdby && !upd && psel < 5) ? 1 : 0;
      for (int i = 0; i < 5; i++) begin
        d = (m_adiv[i] == 0) ? 1 : m_adiv[i];
        if (upd || stdby) begin
          m_ce[i] = 0; m_cd[i] = 0; m_cnt[i] = 0;
        end else begin
          m_ce[i] = (m_aen[i] == 1 && m_lk == 1 && m_cnt[i] == m_aph[i]) ? 1 : 0;
          m_cd[i] = (m_aen[i] == 1 && m_lk == 1 && 2 * m_cnt[i] < d) ? 1 : 0;
          if (acc == 1 && psel == i) begin
            if (!pud) m_cnt[i] = (m_cnt[i] + 2) % d;
          end else begin
            m_cnt[i] = (m_cnt[i] + 1) % d;
          end
        end
      end
      if (upd) begin
        for (int i = 0; i < 5; i++) begin
          m_adiv[i] = m_sdiv[i];
          d = (m_sdiv[i] == 0) ? 1 : m_sdiv[i];
          m_aph[i] = (m_sph[i] >= d) ? d - 1 : m_sph[i];
          m_aen[i] = m_sen[i];
        end
      end
      if (upd || stdby) begin
        m_lkc = 0; m_lk = 0;
      end else if (m_lk == 0) begin
        if (m_lkc == 63) m_lk = 1;
        else             m_lkc++;
      end
      m_pd = acc;
    end
    e = '0;
    for (int i = 0; i < 5; i++) begin
      e[7+i] = m_ce[i][0];
      e[2+i] = m_cd[i][0];
    end
    e[1] = m_pd[0];
    e[0] = m_lk[0];
    sb.push_back(e);
  endtask

  task automatic tick();
    logic [11:0] exp;
    model_step();
    @(posedge refclk);
    #1;
    exp = sb.pop_front();
    chk("cycle", {clken, clkdiv, phasedone, locked}, exp);
    we = 1'b0; upd = 1'b0; pstep = 1'b0;
  endtask

  task automatic wait_lock(output int cnt);
    cnt = 0;
    do begin tick(); cnt++; end while (!locked && cnt < 200);
    if (!locked) chk("lock_timeout", locked, 1);
  endtask

  task automatic wait_pulse(output int cnt);
    cnt = 0;
    do begin tick(); cnt++; end while (!clken[1] && cnt < 40);
    if (!clken[1]) chk("pulse_timeout", clken[1], 1);
  endtask

  task automatic wr(input int ch, input int dv, input int pv, input logic e, input logic u);
    we = 1'b1; sel = 3'(ch); div = 8'(dv); ph = 8'(pv); en = e; upd = u;
    tick();
  endtask

  initial begin
    // Reset state and default lock-up
    for (int i = 0; i < 3; i++) tick();
    chk("reset", {clken, clkdiv, phasedone, locked}, 12'h000);
    rst = 1'b0;
    wait_lock(n);
    chk("lock_lat", n, 64);
    for (int i = 0; i < 4; i++) tick();
    chk("all_ones", {clken, clkdiv}, 10'h3FF);

    // ch1 div4 phase2, ch2 div3 written together with the commit
    wr(1, 4, 2, 1'b1, 1'b0);
    wr(2, 3, 0, 1'b1, 1'b1);
    chk("commit_unlock", locked, 0);
    wait_lock(n);
    chk("relock", n, 64);
    for (int i = 0; i < 12; i++) tick();

    // Delay then advance step on ch1
    wait_pulse(n);
    wait_pulse(n);
    chk("gap_base", n, 4);
    pstep = 1'b1; pud = 1'b1; psel = 3'd1;
    tick();
    chk("phasedone_dly", phasedone, 1);
    wait_pulse(n);
    chk("gap_dly", n + 1, 5);
    wait_pulse(n);
    chk("gap_after", n, 4);
    pstep = 1'b1; pud = 1'b0; psel = 3'd1;
    tick();
    chk("phasedone_adv", phasedone, 1);
    wait_pulse(n);
    chk("gap_adv", n + 1, 3);
    tick();
    chk("phasedone_once", phasedone, 0);

    // Dropped steps: out-of-range channel, and while unlocked
    pstep = 1'b1; pud = 1'b1; psel = 3'd7;
    tick();
    chk("drop_sel7", phasedone, 0);
    upd = 1'b1;
    tick();
    pstep = 1'b1; psel = 3'd1;
    tick();
    chk("drop_unlocked", phasedone, 0);
    wait_lock(n);

    // Standby pulse
    for (int i = 0; i < 6; i++) tick();
    stdby = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("stdby_outs", {clken, clkdiv, locked}, 11'h000);
    stdby = 1'b0;
    wait_lock(n);
    chk("stdby_relock", n, 64);

    // Phase clamp and commit beating a simultaneous step
    pstep = 1'b1; pud = 1'b1; psel = 3'd1;
    wr(1, 4, 9, 1'b1, 1'b1);
    chk("upd_step_drop", phasedone, 0);
    wait_lock(n);
    for (int i = 0; i < 10; i++) tick();

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      we    = ($urandom_range(0, 7) == 0);
      sel   = 3'($urandom_range(0, 7));
      div   = 8'($urandom_range(0, 6));
      ph    = 8'($urandom_range(0, 7));
      en    = 1'($urandom_range(0, 1));
      upd   = ($urandom_range(0, 99) == 0);
      pstep = ($urandom_range(0, 3) == 0);
      pud   = 1'($urandom_range(0, 1));
      psel  = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 99) < 2) stdby = ~stdby;
      tick();
    end
    stdby = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
